// File: rtl/clk_en_pkg.sv
// Shared state type, default parameters and sizing helper for the clk_en_gen
// fractional clock-enable generator.
package clk_en_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    RUN       = 2'd2
  } state_t;

  localparam int DEF_NUM_CH      = 3;
  localparam int DEF_ACC_W       = 24;
  localparam int DEF_LOCK_CYCLES = 1024;

  // Ceiling log2; returns 0 for values of 0 or 1.
  function automatic int clog2(input int value);
    int w;
    w = 0;
    while ((64'd1 << w) < 64'(value)) begin
      w++;
    end
    return w;
  endfunction

endpackage

// File: rtl/clk_en_acc.sv
// One clock-enable channel: a phase accumulator whose carry-out, masked by the
// channel enable, becomes a registered single-cycle ce pulse.
module clk_en_acc #(
  parameter int ACC_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ACC_W-1:0] inc,
  input  logic             mask,
  input  logic             clear,
  input  logic             hold,
  output logic             ce
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ce_q, ce_d;
  logic [ACC_W:0]   sum;

  // Clear dominates hold so leaving RUN always restarts from zero phase; the
  // mask only gates the pulse so the phase keeps running underneath it.
  always_comb begin
    sum   = {1'b0, acc_q} + {1'b0, inc};
    acc_d = acc_q;
    ce_d  = 1'b0;
    if (clear) begin
      acc_d = '0;
    end else if (!hold) begin
      acc_d = sum[ACC_W-1:0];
      ce_d  = sum[ACC_W] & mask;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      ce_q  <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ce_q  <= ce_d;
    end
  end

  assign ce = ce_q;

endmodule

// File: rtl/clk_en_gen.sv
// Multi-channel fractional clock-enable generator: synchronises PLL lock, waits
// for it to settle, then runs one phase-accumulator channel per output enable.
module clk_en_gen
  import clk_en_pkg::*;
#(
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int ACC_W       = DEF_ACC_W,
  parameter int LOCK_CYCLES = DEF_LOCK_CYCLES
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pll_locked,
  input  logic                    pause,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic                    inc_load,
  input  logic [NUM_CH*ACC_W-1:0] inc_in,
  output logic [NUM_CH-1:0]       ce,
  output logic                    ready
);

  localparam int CNT_W = (clog2(LOCK_CYCLES) < 1) ? 1 : clog2(LOCK_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

  logic [1:0]                    sync_q, sync_d;
  logic                          lk_s;
  logic [NUM_CH-1:0][ACC_W-1:0]  inc_q, inc_d;
  state_t                        state_q, state_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic                          ready_q, ready_d;
  logic                          run_active;
  logic                          acc_clear;

  assign lk_s = sync_q[1];

  // Increment registers survive lock loss; only rst clears them.
  always_comb begin
    sync_d = {sync_q[0], pll_locked};
    inc_d  = inc_load ? inc_in : inc_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      inc_q  <= '0;
    end else begin
      sync_q <= sync_d;
      inc_q  <= inc_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= WAIT_LOCK;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  // A low synchronised lock drops straight back to WAIT_LOCK from any state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!lk_s) begin
      state_d = WAIT_LOCK;
      cnt_d   = '0;
    end else begin
      case (state_q)
        WAIT_LOCK: begin
          state_d = SETTLE;
          cnt_d   = '0;
        end
        SETTLE: begin
          if (cnt_q == CNT_LAST) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        RUN: begin
          cnt_d = '0;
        end
        default: begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Channels only advance on edges that start and stay in RUN, so a lock loss
  // coinciding with a carry yields no pulse.
  always_comb begin
    ready_d    = (state_d == RUN);
    run_active = (state_q == RUN) && lk_s;
    acc_clear  = !run_active;
  end

  assign ready = ready_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_en_acc #(
      .ACC_W(ACC_W)
    ) u_acc (
      .clk  (clk),
      .rst  (rst),
      .inc  (inc_q[i]),
      .mask (ch_en[i]),
      .clear(acc_clear),
      .hold (pause),
      .ce   (ce[i])
    );
  end

endmodule

// File: doc/clk_en_gen.md
Name: clk_en_gen

Overview:
- Multi-channel fractional clock-enable generator. It is the parametrised successor to the fixed three-output PLL wrapper.
- Runs entirely in one PLL output domain (e.g. 36.864 MHz system clock). Derives NUM_CH independent, runtime-programmable clock-enable pulse trains (CPU, audio, video) by phase accumulation, instead of burning extra PLL outputs.
- Gates all enables on a synchronised, debounced PLL lock so downstream logic never sees enables from an unstable clock.

Parameters:
- NUM_CH, 3, number of clock-enable channels (1..8)
- ACC_W, 24, phase accumulator width per channel (4..32)
- LOCK_CYCLES, 1024, consecutive synced-locked cycles required before RUN (>=1)

Ports:
- clk  in  1  system clock (PLL output)
- rst  in  1  asynchronous active-high reset
- pll_locked  in  1  raw PLL lock, asynchronous to clk
- pause  in  1  freeze all accumulators, suppress all ce
- ch_en  in  NUM_CH  per-channel ce mask
- inc_load  in  1  one-cycle strobe: capture inc_in into all increment registers
- inc_in  in  NUM_CH*ACC_W  packed increments, channel i at [i*ACC_W +: ACC_W]
- ce  out  NUM_CH  registered one-cycle enable pulses
- ready  out  1  high while in RUN

Behaviour:
- Reset (async, active-high) values: ce=0, ready=0, all accumulators=0, all increment registers=0, sync flops=0, settle counter=0, state=WAIT_LOCK.
- Lock synchroniser: two flops on pll_locked produce lk_s. All decisions use lk_s only, so there are 2 cycles of latency from the raw input.
- State machine:
  - WAIT_LOCK: counter=0; on lk_s=1 go to SETTLE.
  - SETTLE: counter increments each cycle lk_s=1. When counter reaches LOCK_CYCLES-1 with lk_s=1, go to RUN. lk_s=0 returns to WAIT_LOCK with counter cleared.
  - RUN: ready=1. lk_s=0 goes to WAIT_LOCK.
  - From any state, lk_s=0 forces WAIT_LOCK on the next edge.
- ready is registered and equals (state==RUN). It deasserts on the same edge that leaves RUN.
- Accumulator update, per channel, in RUN with pause=0, every edge:
  - {carry, acc} <= acc + inc, computed at ACC_W+1 bits.
  - ce[i] <= carry & ch_en[i].
- Output frequency per channel = f_clk * inc / 2^ACC_W. inc=0 never pulses. The maximum rate is inc=2^ACC_W-1; a 100% duty enable cannot be represented.
- Latency: the accumulator is 0 on entry to RUN. The first ce asserts on the edge where the sum first carries. Example (ACC_W=8, inc=64): ce is high after the 4th RUN edge, then every 4th cycle.
- ch_en=0 masks ce only. The accumulator keeps running so phase is preserved when the channel is re-enabled.
- pause=1: accumulators hold and ce=0 on the next edge. Resuming continues from the held phase.
- Outside RUN: accumulators are cleared to 0 and ce=0 on the next edge.
- Increment registers are retained across lock loss; only rst clears them.
- inc_load: increments are captured on the strobe edge. The update on that same edge uses the old inc; the new inc takes effect from the next edge. inc_load is accepted in any state.
- Simultaneous events:
  - Lock loss and carry on the same edge: lock loss wins, ce=0.
  - pause and inc_load on the same edge: both honoured.

Decomposition:
- Package clk_en_pkg: state enum (WAIT_LOCK, SETTLE, RUN), a lock-counter width function clog2(LOCK_CYCLES), and default parameter constants.
- Sub-module clk_en_acc: one channel. Inputs are increment register, accumulator, carry, mask and clear/hold controls. It is instantiated NUM_CH times by a generate loop.
- The top level holds the synchroniser, FSM and settle counter.

Test Plan:
1. rst high, pll_locked=1, then release rst. Expect ready=0 for 2 sync cycles plus LOCK_CYCLES cycles, then ready=1. With LOCK_CYCLES=16, ready rises exactly 18 edges after lk input first samples high.
2. ACC_W=8, inc={64,85,0}, all ch_en=1, in RUN:
   - ch0 pulses every 4 cycles.
   - ch1 produces 85 pulses per 256 cycles, with spacing 3 or 4.
   - ch2 never pulses.
   - Each pulse is 1 cycle wide.
3. Drop pll_locked for 1 raw cycle in SETTLE, then for 5 cycles in RUN:
   - SETTLE restarts from zero.
   - In RUN, ready and all ce fall within 3 edges of the drop.
   - After relock, the first ch0 pulse arrives exactly 4 edges after RUN re-entry (accumulator cleared).
4. pause=1 for 10 cycles mid-run with ch0 inc=64, acc=128: no ce during the pause. The first ce arrives 2 edges after pause=0.
5. Assert inc_load with inc 64->128 on the same edge that ch0 carries:
   - That carry still produces ce.
   - Subsequent ce pulses come every 2 cycles.
6. ch_en[0]=0 for 7 cycles then 1 (inc=64): ce is masked during those cycles, and later pulses stay on the original 4-cycle grid.
